// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and
// default burst/hold limits.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_ARB       = 3'd0,
    ST_ACCEPT    = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HOLD      = 3'd5
  } arb_state_t;

  localparam int UART_MAX_BURST    = 16;
  localparam int UART_HOLD_TIMEOUT = 64;
  // A transmitter that never drops tx_ready is trusted after this many cycles.
  localparam int BUSY_WAIT_CYCLES  = 4;

  function automatic logic [1:0] next_owner(input logic [1:0] owner);
    return owner + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request bit at or after ptr,
// wrapping 3 -> 0.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       found
);

  logic [1:0] cand;

  // Scan farthest offset first so the nearest requester overrides.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Four-requester byte arbiter in front of a single UART transmitter, with
// message locking, burst limiting and idle-hold release.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int MAX_BURST    = UART_MAX_BURST,
  parameter int HOLD_TIMEOUT = UART_HOLD_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_req,
  output logic [1:0]  grant_id,
  output logic        busy
);

  localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);
  localparam logic [7:0] IDLE_LAST   = 8'(HOLD_TIMEOUT - 1);
  localparam logic [2:0] WB_LAST     = 3'(BUSY_WAIT_CYCLES - 1);

  arb_state_t state, state_nxt;

  logic [1:0] rr_ptr;
  logic [1:0] grant;
  logic [7:0] burst_cnt;
  logic [7:0] idle_cnt;
  logic [2:0] wb_cnt;
  logic [7:0] byte_p0;
  logic       last_p0;

  logic [1:0] pick_idx;
  logic       pick_found;
  logic       handshake;
  logic       msg_done;
  logic       hold_expire;
  logic       release_grant;

  rr_pick4 u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign handshake     = (state == ST_ACCEPT) && req_valid[grant] && tx_ready;
  assign msg_done      = last_p0 || (burst_cnt == BURST_LIMIT);
  assign hold_expire   = (state == ST_HOLD) && !req_valid[grant] && (idle_cnt == IDLE_LAST);
  assign release_grant = ((state == ST_WAIT_DONE) && tx_ready && msg_done) || hold_expire;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:       if (pick_found) state_nxt = ST_ACCEPT;
      ST_ACCEPT:    if (handshake) state_nxt = ST_SEND;
      ST_SEND:      state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (!tx_ready || (wb_cnt == WB_LAST)) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_ready) state_nxt = msg_done ? ST_ARB : ST_HOLD;
      ST_HOLD: begin
        if (req_valid[grant])  state_nxt = ST_ACCEPT;
        else if (hold_expire)  state_nxt = ST_ARB;
      end
      default:      state_nxt = ST_ARB;
    endcase
  end

  // Grant, byte latch and the burst / busy-wait / idle counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      grant     <= '0;
      burst_cnt <= '0;
      idle_cnt  <= '0;
      wb_cnt    <= '0;
      byte_p0   <= '0;
      last_p0   <= 1'b0;
    end else begin
      if ((state == ST_ARB) && pick_found) begin
        grant     <= pick_idx;
        burst_cnt <= '0;
      end
      if (handshake) begin
        byte_p0 <= req_data[{grant, 3'b000} +: 8];
        last_p0 <= req_last[grant];
      end
      if (state == ST_SEND) begin
        burst_cnt <= burst_cnt + 8'd1;
        wb_cnt    <= '0;
      end
      if (state == ST_WAIT_BUSY) wb_cnt <= wb_cnt + 3'd1;
      if (state == ST_WAIT_DONE) idle_cnt <= '0;
      if ((state == ST_HOLD) && !req_valid[grant]) idle_cnt <= idle_cnt + 8'd1;
      if (release_grant) rr_ptr <= next_owner(grant);
    end
  end

  always_comb begin
    req_ready = '0;
    if (handshake) req_ready[grant] = 1'b1;
    tx_req   = (state == ST_SEND);
    tx_data  = byte_p0;
    grant_id = grant;
    busy     = (state != ST_ARB);
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a transmitter
// model drive the DUT; a monitor checks every transmitted byte and owner.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic [1:0]  grant_id;
  logic        busy;

  uart_tx_arbiter #(.MAX_BURST(16), .HOLD_TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [1:0] id; logic [7:0] data; } exp_t;
  typedef struct packed { logic [7:0] data; logic last; } byte_t;

  exp_t  exp_q[$];
  byte_t chmem [4][64];
  int    head [4];
  int    tail [4];
  logic [3:0] hs;
  logic  stuck = 1'b0;
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    last_tx = -1;
  int    last_gap = 0;
  int    tx_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic load(input int ch, input logic [7:0] d, input logic l);
    chmem[ch][tail[ch]] = {d, l};
    tail[ch]++;
  endtask

  task automatic expect_tx(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: present the head byte, advance after each accepted handshake.
  initial begin
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (rst) begin
          head[i] = 0;
          tail[i] = 0;
        end else if (hs[i] && head[i] != tail[i]) begin
          head[i]++;
        end
        req_valid[i] = (head[i] != tail[i]);
        req_data[8*i +: 8] = req_valid[i] ? chmem[i][head[i]].data : 8'h00;
        req_last[i] = req_valid[i] ? chmem[i][head[i]].last : 1'b0;
      end
    end
  end

  // Transmitter: busy for three cycles after each strobe unless stuck idle.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_req && !stuck) begin
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // Monitor: owner of every accept, data/owner of every strobe, strobe spacing.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_ready != 4'b0000) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL req_ready_unexpected: actual 0x%0h required 0x0", req_ready);
        end else begin
          check("req_ready_owner", {28'd0, req_ready}, 32'd1 << exp_q[0].id);
        end
      end
      if (tx_req) begin
        tx_seen++;
        if (last_tx >= 0) begin
          last_gap = cyc - last_tx;
          n_chk++;
          if (last_gap < 3) begin
            n_fail++;
            $display("FAIL tx_req_spacing: actual %0d cycles required >= 3", last_gap);
          end
        end
        last_tx = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_req_unexpected: actual data 0x%0h required no strobe", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
          check("tx_grant_id", {30'd0, grant_id}, {30'd0, e.id});
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_tx = -1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (exp_q.size() == 0 && !busy)}, 32'd1);
  endtask

  task automatic wait_tx_ready(input logic lvl, input int budget, input string name);
    int n;
    n = 0;
    while (tx_ready !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, tx_ready}, {31'd0, lvl});
  endtask

  initial begin
    int hold_cnt;
    int seen0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_tx_req", {31'd0, tx_req}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_grant_id", {30'd0, grant_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Single channel 2, three-byte message
    load(2, 8'hA1, 1'b0); load(2, 8'hA2, 1'b0); load(2, 8'hA3, 1'b1);
    expect_tx(2'd2, 8'hA1); expect_tx(2'd2, 8'hA2); expect_tx(2'd2, 8'hA3);
    wait_idle("ch2_msg_done", 200);
    // Pointer now sits at 3: ch3 wins over ch1
    load(1, 8'h61, 1'b1); load(3, 8'h63, 1'b1);
    expect_tx(2'd3, 8'h63); expect_tx(2'd1, 8'h61);
    wait_idle("rr_ptr_after_ch2", 200);

    // Four channels, one-byte messages: order 0,1,2,3,0
    do_reset();
    load(0, 8'hB0, 1'b1); load(0, 8'hB4, 1'b1);
    load(1, 8'hB1, 1'b1); load(2, 8'hB2, 1'b1); load(3, 8'hB3, 1'b1);
    expect_tx(2'd0, 8'hB0); expect_tx(2'd1, 8'hB1); expect_tx(2'd2, 8'hB2);
    expect_tx(2'd3, 8'hB3); expect_tx(2'd0, 8'hB4);
    wait_idle("round_robin_order", 300);

    // Burst limit: 16 bytes of ch0, then ch1, then ch0's remaining 4
    do_reset();
    for (int i = 0; i < 20; i++) load(0, 8'(8'h10 + i), 1'b0);
    load(1, 8'hE1, 1'b1);
    for (int i = 0; i < 16; i++) expect_tx(2'd0, 8'(8'h10 + i));
    expect_tx(2'd1, 8'hE1);
    for (int i = 16; i < 20; i++) expect_tx(2'd0, 8'(8'h10 + i));
    wait_idle("burst_limit", 800);

    // Hold timeout: ch1 idles after one byte, released after 64 hold cycles
    do_reset();
    load(1, 8'h5A, 1'b0); load(3, 8'hC3, 1'b1);
    expect_tx(2'd1, 8'h5A); expect_tx(2'd3, 8'hC3);
    wait_tx_ready(1'b0, 20, "hold_tx_busy");
    wait_tx_ready(1'b1, 10, "hold_tx_done");
    hold_cnt = 0;
    @(negedge clk);
    while (busy && hold_cnt < 200) begin
      hold_cnt++;
      @(negedge clk);
    end
    check("hold_timeout_cycles", hold_cnt, 32'd64);
    wait_idle("hold_then_ch3", 200);

    // Reset in WAIT_DONE abandons the message
    do_reset();
    load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b1);
    expect_tx(2'd2, 8'h11);
    wait_tx_ready(1'b0, 20, "rst_mid_tx_busy");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", {28'd0, req_ready}, 32'd0);
    check("midrst_tx_req", {31'd0, tx_req}, 32'd0);
    check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    check("midrst_grant_id", {30'd0, grant_id}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    seen0 = tx_seen;
    repeat (30) @(negedge clk);
    check("midrst_no_tx", tx_seen - seen0, 32'd0);
    check("midrst_queue_empty", exp_q.size(), 32'd0);

    // Transmitter never drops tx_ready: busy-wait gives up after 4 cycles
    stuck = 1'b1;
    do_reset();
    load(0, 8'h31, 1'b0); load(0, 8'h32, 1'b1);
    expect_tx(2'd0, 8'h31); expect_tx(2'd0, 8'h32);
    wait_idle("stuck_ready_done", 200);
    check("stuck_ready_gap", last_gap, 32'd8);
    stuck = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
